hbridge_pwm_driver: RTL

- Consumer end of the robot motor-command interface: takes per-motor direction commands from the navigation FSM and drives two H-bridge channels (A, B) with PWM.
- Guarantees shoot-through-safe direction reversal by inserting a coast (dead-time) interval.
- Sits between the navigation FSM outputs and the bidirectional pad pins feeding the external motor driver.

---
 rtl/motor_pkg.sv | 36 +++
 rtl/hbridge_channel.sv | 126 ++++++++++++
 rtl/hbridge_pwm_driver.sv | 105 ++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the H-bridge PWM driver: motor command encodings,
// per-channel state encodings and the bridge pin decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package motor_pkg;

    typedef enum logic [1:0] {
        CMD_COAST = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_REV   = 2'b10,
        CMD_BRAKE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_DEAD  = 2'b10
    } ch_state_e;

    // Returns {in1, in2} for a driving command. Brake holds both inputs high
    // and ignores the PWM phase; coast releases both.
    function automatic logic [1:0] pin_decode(input logic [1:0] cmd,
                                              input logic       pwm_on);
        logic [1:0] pins;
        case (cmd)
            CMD_FWD:   pins = {pwm_on, 1'b0};
            CMD_REV:   pins = {1'b0, pwm_on};
            CMD_BRAKE: pins = 2'b11;
            default:   pins = 2'b00;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/hbridge_channel.sv
// ---------------------------------------------------------------------------
// hbridge_channel
// One H-bridge channel: command sample register, period-aligned duty latch,
// IDLE/DRIVE/DEAD state machine with dead-time counter, registered pins.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   enable       global drive enable; low forces IDLE and pins low
//   wrap         high on the cycle whose edge brings the PWM counter to 0
//   cnt          shared PWM counter
//   cmd          motor command (coast/fwd/rev/brake)
//   duty         requested duty, latched at wrap
//   in1, in2     registered bridge inputs
//   busy         high while the channel is in dead time
// ---------------------------------------------------------------------------
module hbridge_channel
    import motor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DEAD_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       cmd,
    input  logic [CNT_W-1:0] duty,
    output logic             in1,
    output logic             in2,
    output logic             busy
);

    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC - 1);

    logic [1:0]       cmd_q, cmd_d;
    logic [CNT_W-1:0] duty_lat_q, duty_lat_d;
    ch_state_e        state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       pend_q, pend_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [1:0]       pins_q, pins_d;
    logic             pwm_on;

    assign pwm_on = (cnt < duty_lat_q);

    always_comb begin
        cmd_d      = cmd;
        duty_lat_d = wrap ? duty : duty_lat_q;
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        dead_d     = dead_q;

        if (!enable) begin
            state_d = ST_IDLE;
            dead_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_q != CMD_COAST) begin
                        state_d = ST_DRIVE;
                        cur_d   = cmd_q;
                    end
                end
                ST_DRIVE: begin
                    if (cmd_q == CMD_COAST) begin
                        state_d = ST_IDLE;
                    end else if (cmd_q != cur_q) begin
                        state_d = ST_DEAD;
                        pend_d  = cmd_q;
                        dead_d  = DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (cmd_q == CMD_COAST) begin
                        state_d = ST_IDLE;
                        dead_d  = '0;
                    end else if (dead_q == '0) begin
                        // A command change on this final cycle is picked up
                        // from DRIVE on the next cycle as a fresh reversal.
                        state_d = ST_DRIVE;
                        cur_d   = pend_q;
                    end else begin
                        // Retargeting during dead time keeps the count running.
                        pend_d = cmd_q;
                        dead_d = dead_q - DW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Pins follow the next state so they change on the same edge as the
        // state register; this makes the zero window exactly DEAD_CYC long.
        pins_d = (state_d == ST_DRIVE) ? pin_decode(cur_d, pwm_on) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q      <= 2'b00;
            duty_lat_q <= '0;
            state_q    <= ST_IDLE;
            cur_q      <= 2'b00;
            pend_q     <= 2'b00;
            dead_q     <= '0;
            pins_q     <= 2'b00;
        end else begin
            cmd_q      <= cmd_d;
            duty_lat_q <= duty_lat_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            dead_q     <= dead_d;
            pins_q     <= pins_d;
        end
    end

    assign in1  = pins_q[1];
    assign in2  = pins_q[0];
    assign busy = (state_q == ST_DEAD);

endmodule

// File: rtl/hbridge_pwm_driver.sv
// ---------------------------------------------------------------------------
// hbridge_pwm_driver
// Two-channel H-bridge PWM driver with shoot-through-safe direction reversal.
// Holds the shared prescaler, PWM counter and period_start strobe, and two
// independent hbridge_channel instances.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enable              global drive enable
//   cmd_a, cmd_b        per-motor commands (00 coast, 01 fwd, 10 rev, 11 brake)
//   duty_a, duty_b      per-motor duty, applied from the next PWM period
//   a_in1/a_in2         bridge A inputs
//   b_in1/b_in2         bridge B inputs
//   a_busy, b_busy      channel in dead time
//   period_start        one-clk pulse when the PWM counter wraps to 0
// ---------------------------------------------------------------------------
module hbridge_pwm_driver
    import motor_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEAD_CYC = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       cmd_a,
    input  logic [1:0]       cmd_b,
    input  logic [CNT_W-1:0] duty_a,
    input  logic [CNT_W-1:0] duty_b,
    output logic             a_in1,
    output logic             a_in2,
    output logic             b_in1,
    output logic             b_in2,
    output logic             a_busy,
    output logic             b_busy,
    output logic             period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_start_q, period_start_d;
    logic             tick;
    logic             wrap;

    assign tick = (presc_q == PRESC_TC);
    // High on the cycle whose closing edge brings the counter back to 0.
    assign wrap = tick && (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        presc_d        = tick ? '0 : presc_q + PW'(1);
        cnt_d          = tick ? cnt_q + CNT_W'(1) : cnt_q;
        period_start_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    hbridge_channel #(
        .CNT_W    (CNT_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .wrap   (wrap),
        .cnt    (cnt_q),
        .cmd    (cmd_a),
        .duty   (duty_a),
        .in1    (a_in1),
        .in2    (a_in2),
        .busy   (a_busy)
    );

    hbridge_channel #(
        .CNT_W    (CNT_W),
        .DEAD_CYC (DEAD_CYC)
    ) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .wrap   (wrap),
        .cnt    (cnt_q),
        .cmd    (cmd_b),
        .duty   (duty_b),
        .in1    (b_in1),
        .in2    (b_in2),
        .busy   (b_busy)
    );

endmodule
